fifo_spi_serializer: RTL and testbench
======================================

Name: fifo_spi_serializer

Overview:
- Downstream consumer of the transmit FIFO (32-bit words, depth 256).
- Pops one word whenever the FIFO is non-empty and enabled, then shifts it out as a single SPI mode-0 frame (CPOL=0, CPHA=0), MSB first.
- Drives the external SPI pins: SCLK, MOSI and active-low chip select.
- Pulses `done_o` once per completed frame.

Parameters:
- DATA_WIDTH, 32 (`DATA_WIDTH): frame/word width in bits.
- CLK_DIV, 2: system clocks per SCLK half-period. Must be ≥1.
- CS_GAP, 4: minimum clocks with cs_n high between frames. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  permits new frames to start. Sampled only in IDLE.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  DATA_WIDTH  FIFO read data. Valid the cycle after fifo_rd_en_o.
- fifo_rd_en_o  out  1  one-cycle pop strobe.
- sclk_o  out  1  SPI clock. Idles low.
- mosi_o  out  1  SPI data out.
- cs_n_o  out  1  chip select, active low.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values (asynchronous, all outputs): sclk_o=0, mosi_o=0, cs_n_o=1, fifo_rd_en_o=0, busy_o=0, done_o=0. All counters 0, state IDLE.
- FSM states: IDLE, POP, LOAD, SHIFT, DONE, GAP.
- IDLE:
  - If enable_i && !fifo_empty_i: fifo_rd_en_o=1 for this cycle (call it t0), next state POP.
  - Otherwise stay in IDLE. fifo_rd_en_o is never asserted while fifo_empty_i=1.
- POP (t0+1): fifo_data_i is valid. Capture it into the shift register, go to LOAD.
- LOAD (t0+2):
  - cs_n_o=0, mosi_o=shreg[DATA_WIDTH-1], sclk_o=0.
  - Bit counter = DATA_WIDTH-1, divider = 0. Go to SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV-1; each wrap toggles sclk_o.
  - Rising edge: no data change; the slave samples.
  - Falling edge: if bit counter ≠ 0, shift left, drive the next bit onto mosi_o and decrement the counter. If the counter is 0, go to DONE.
- Frame timing: cs_n_o is low for exactly 2·CLK_DIV·DATA_WIDTH cycles (plus 1 for LOAD). The first rising edge of sclk_o occurs at t0+2+CLK_DIV.
- DONE (one cycle): cs_n_o=1, sclk_o=0, mosi_o=0, done_o=1. Go to GAP.
- GAP: cs_n_o held high for CS_GAP cycles, then IDLE. The earliest next fifo_rd_en_o is the cycle IDLE is entered.
- enable_i deasserted mid-frame: the current frame completes normally; no new pop.
- fifo_empty_i asserted during a frame: ignored; the word is already captured.
- Bit counter width: `BIT_COUNTER_WIDTH ($clog2(DATA_WIDTH)=5`). The divider counter width is $clog2(CLK_DIV)+1. No wrap-around is possible beyond the defined ranges.
- Reset mid-frame: the frame is aborted immediately and cs_n_o goes high asynchronously. The captured word is lost and is not re-popped.

Optional Feature:
- Macro: FIFO_SPI_LSB_FIRST_EN.
- Defined: the shift register shifts right and mosi_o = shreg[0]; bit order is LSB first. Timing is otherwise identical.
- Undefined: MSB first, as specified above.

Decomposition:
- fifo_defines_pkg gains:
  - typedef enum logic [2:0] spi_state_t {IDLE, POP, LOAD, SHIFT, DONE, GAP};
  - constants SPI_CLK_DIV and SPI_CS_GAP.
- DATA_WIDTH and BIT_COUNTER_WIDTH are reused from the package.
- One sub-module: spi_clk_div. It takes CLK_DIV, has inputs en and clear, and outputs a rise_tick/fall_tick pair plus sclk. It owns the divider counter. The top module owns the FSM, shift register and bit counter.

Test Plan:
- Reset: hold rst_n=0 with fifo_empty_i=0 and enable_i=1 → cs_n_o=1, sclk_o=0, fifo_rd_en_o=0 throughout. The first pop occurs the first clock edge after release.
- Single word, CLK_DIV=2: push 32'hA5A5_0F0F.
  - Expected: one rd_en pulse; cs_n_o low for 129 cycles; 32 rising SCLK edges; MOSI sampled on rises = A5A50F0F MSB first; done_o one pulse.
- Back-to-back, CS_GAP=4: two words 32'hFFFF_FFFF then 32'h0000_0001.
  - Expected: two frames with ≥5 cycles of cs_n_o high between them (DONE+GAP); the second frame's MOSI is 31 zeros then 1.
- Flow control: enable_i=0 with a non-empty FIFO → no rd_en and busy_o=0. Drop enable_i mid-frame → the frame completes and no further pops occur.
- Abort: assert rst_n=0 at bit 10 of a frame → cs_n_o=1 and sclk_o=0 immediately; no done_o pulse.
- With FIFO_SPI_LSB_FIRST_EN defined, word 32'h0000_0001 → MOSI=1 on the first rise, 0 on the remaining 31.

Source files
------------

// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the transmit-FIFO SPI serializer: word width,
// bit counter width, SPI timing defaults and the serializer state encoding.
package fifo_defines_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int BIT_COUNTER_WIDTH = $clog2(DATA_WIDTH);

  localparam int SPI_CLK_DIV = 2;
  localparam int SPI_CS_GAP  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: counts CLK_DIV system clocks per SCLK half-period and
// flags the system-clock edge on which SCLK rises or falls.
module spi_clk_div
  import fifo_defines_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int               CNT_W    = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  // Divider count and SCLK toggle; clear parks SCLK low with the count at 0.
  always_comb begin
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    wrap      = en && !clear && (cnt_q == CNT_LAST);
    rise_tick = wrap && !sclk_q;
    fall_tick = wrap && sclk_q;
    if (clear) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/fifo_spi_serializer.sv
// Pops 32-bit words from the transmit FIFO and sends each one as a single
// SPI mode-0 frame. Default bit order is MSB first; defining
// FIFO_SPI_LSB_FIRST_EN sends LSB first with identical timing.
module fifo_spi_serializer
  import fifo_defines_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int CS_GAP  = SPI_CS_GAP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  cs_n_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                           GAP_W    = $clog2(CS_GAP) + 1;
  localparam logic [GAP_W-1:0]             GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] BIT_LAST = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  spi_state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]        shreg_q, shreg_d;
  logic [BIT_COUNTER_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]             gap_cnt_q, gap_cnt_d;
  logic                         cs_n_q, cs_n_d;
  logic                         mosi_q, mosi_d;
  logic                         done_q, done_d;

  logic div_en, div_clear;
  logic rise_tick, fall_tick, sclk;
  logic rise_tick_unused;

  // The divider runs from LOAD onward so LOAD counts as the first half-period
  // cycle; it is held clear in every other state.
  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (div_en),
    .clear     (div_clear),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  // Rising SCLK edges are where the slave samples; MOSI only moves on falls.
  assign rise_tick_unused = rise_tick;

  // Next-state, datapath and pop strobe. The pop is gated by rst_n so no
  // word is ever requested while reset is held.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    done_d       = 1'b0;
    fifo_rd_en_o = 1'b0;
    div_en       = 1'b0;
    div_clear    = 1'b1;

    case (state_q)
      IDLE: begin
        if (rst_n && enable_i && !fifo_empty_i) begin
          fifo_rd_en_o = 1'b1;
          state_d      = POP;
        end
      end

      POP: begin
        shreg_d   = fifo_data_i;
        bit_cnt_d = BIT_LAST;
        cs_n_d    = 1'b0;
`ifdef FIFO_SPI_LSB_FIRST_EN
        mosi_d    = fifo_data_i[0];
`else
        mosi_d    = fifo_data_i[DATA_WIDTH-1];
`endif
        state_d   = LOAD;
      end

      LOAD: begin
        div_en    = 1'b1;
        div_clear = 1'b0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        div_en    = 1'b1;
        div_clear = 1'b0;
        if (fall_tick) begin
          if (bit_cnt_q != '0) begin
`ifdef FIFO_SPI_LSB_FIRST_EN
            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            mosi_d  = shreg_q[1];
`else
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d  = shreg_q[DATA_WIDTH-2];
`endif
            bit_cnt_d = bit_cnt_q - BIT_COUNTER_WIDTH'(1);
          end else begin
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        cs_n_d    = 1'b1;
        gap_cnt_d = '0;
        state_d   = GAP;
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and pin registers; reset aborts any frame and raises cs_n at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  // Shift register holds payload only; its content is meaningless outside a frame.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign sclk_o = sclk;
  assign mosi_o = mosi_q;
  assign cs_n_o = cs_n_q;
  assign done_o = done_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_spi_serializer.sv
// Directed bench for fifo_spi_serializer (CLK_DIV=2, CS_GAP=4). Honors
// FIFO_SPI_LSB_FIRST_EN for the expected bit order.
module tb_fifo_spi_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_rd_en_o;
  logic        sclk_o;
  logic        mosi_o;
  logic        cs_n_o;
  logic        busy_o;
  logic        done_o;

  fifo_spi_serializer #(
    .CLK_DIV (2),
    .CS_GAP  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .sclk_o       (sclk_o),
    .mosi_o       (mosi_o),
    .cs_n_o       (cs_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model contents
  logic [31:0] fifo_mem[$];

  // Per-frame monitor state
  int          cyc;
  int          n_pop, n_done, n_rise, n_cs_low, n_busy;
  int          first_pop_cyc, first_cs_fall_cyc, first_rise_cyc;
  logic        first_rise_mosi;
  logic [31:0] rx_word;
  bit          frame_end;

  // Whole-run monitor state
  int   hi_run     = 0;
  int   gap_seen   = 0;
  int   n_bad_pop  = 0;
  int   n_sclk_bad = 0;
  logic cs_prev    = 1'b1;
  logic sclk_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
    logic [31:0] r;
`ifdef FIFO_SPI_LSB_FIRST_EN
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic clear_frame();
    cyc = 0; n_pop = 0; n_done = 0; n_rise = 0; n_cs_low = 0; n_busy = 0;
    first_pop_cyc = -1; first_cs_fall_cyc = -1; first_rise_cyc = -1;
    first_rise_mosi = 1'b0; rx_word = '0; frame_end = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  // One clock: sample on the falling edge, then serve a pop after the rising edge.
  task automatic tick();
    logic popped;
    @(negedge clk);
    popped = (fifo_rd_en_o === 1'b1);
    if (popped) begin
      n_pop++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      if (fifo_empty_i) n_bad_pop++;
    end
    if (busy_o === 1'b1) n_busy++;
    if (done_o === 1'b1) n_done++;
    if (cs_n_o === 1'b0) begin
      n_cs_low++;
      if (cs_prev === 1'b1) begin
        gap_seen = hi_run;
        if (first_cs_fall_cyc < 0) first_cs_fall_cyc = cyc;
      end
      hi_run = 0;
      if (sclk_o === 1'b1 && sclk_prev === 1'b0) begin
        n_rise++;
        rx_word = {rx_word[30:0], mosi_o};
        if (first_rise_cyc < 0) begin
          first_rise_cyc  = cyc;
          first_rise_mosi = mosi_o;
        end
      end
    end else begin
      hi_run++;
      if (cs_prev === 1'b0) frame_end = 1'b1;
      if (sclk_o !== 1'b0) n_sclk_bad++;
    end
    cs_prev   = cs_n_o;
    sclk_prev = sclk_o;
    cyc++;
    @(posedge clk);
    #1;
    if (popped && fifo_mem.size() > 0) begin
      fifo_data_i  = fifo_mem.pop_front();
      fifo_empty_i = (fifo_mem.size() == 0);
    end
  endtask

  task automatic run_frame(input string tag, input int budget);
    for (int i = 0; i < budget && !frame_end; i++) tick();
    check({tag, "_frame_end_seen"}, {31'd0, frame_end}, 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    enable_i     = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    clear_frame();
    push(32'hA5A5_0F0F);

    // Reset held with a non-empty FIFO and enable high
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_cs_n", {31'd0, cs_n_o}, 32'd1);
      check("rst_sclk", {31'd0, sclk_o}, 32'd0);
      check("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    end
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_mosi", {31'd0, mosi_o}, 32'd0);

    // Single word right after reset release
    clear_frame();
    rst_n = 1'b1;
    run_frame("single", 300);
    check("single_pop_after_release", first_pop_cyc, 32'd0);
    check("single_pops", n_pop, 32'd1);
    check("single_cs_low_cycles", n_cs_low, 32'd129);
    check("single_cs_fall_lat", first_cs_fall_cyc - first_pop_cyc, 32'd2);
    check("single_first_rise_lat", first_rise_cyc - first_pop_cyc, 32'd4);
    check("single_rises", n_rise, 32'd32);
    check("single_word", rx_word, exp_word(32'hA5A5_0F0F));
    check("single_done", n_done, 32'd1);
    check("single_mosi_after", {31'd0, mosi_o}, 32'd0);
    check("single_busy_in_gap", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check("single_idle_busy", {31'd0, busy_o}, 32'd0);
    check("single_no_extra_pop", n_pop, 32'd1);

    // Back-to-back frames
    clear_frame();
    push(32'hFFFF_FFFF);
    push(32'h0000_0001);
    run_frame("b2b1", 300);
    check("b2b1_word", rx_word, exp_word(32'hFFFF_FFFF));
    check("b2b1_rises", n_rise, 32'd32);
    check("b2b1_cs_low_cycles", n_cs_low, 32'd129);
    check("b2b1_done", n_done, 32'd1);
    clear_frame();
    run_frame("b2b2", 300);
    check("b2b2_gap_ge5", {31'd0, gap_seen >= 5}, 32'd1);
    check("b2b2_word", rx_word, exp_word(32'h0000_0001));
`ifdef FIFO_SPI_LSB_FIRST_EN
    check("b2b2_first_rise_mosi", {31'd0, first_rise_mosi}, 32'd1);
`else
    check("b2b2_first_rise_mosi", {31'd0, first_rise_mosi}, 32'd0);
`endif
    check("b2b2_rises", n_rise, 32'd32);
    check("b2b2_pops", n_pop, 32'd1);
    check("b2b2_done", n_done, 32'd1);
    for (int i = 0; i < 8; i++) tick();

    // Flow control: disabled with data waiting
    clear_frame();
    enable_i = 1'b0;
    push(32'hC3C3_3C3C);
    for (int i = 0; i < 20; i++) tick();
    check("flow_disabled_pops", n_pop, 32'd0);
    check("flow_disabled_busy", n_busy, 32'd0);

    // Enable drops mid-frame with more data waiting
    clear_frame();
    enable_i = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("flow_midframe_busy", {31'd0, busy_o}, 32'd1);
    enable_i = 1'b0;
    push(32'h1234_5678);
    run_frame("flow", 300);
    check("flow_word", rx_word, exp_word(32'hC3C3_3C3C));
    check("flow_rises", n_rise, 32'd32);
    check("flow_done", n_done, 32'd1);
    check("flow_pops", n_pop, 32'd1);
    clear_frame();
    for (int i = 0; i < 20; i++) tick();
    check("flow_no_pop_after", n_pop, 32'd0);
    check("flow_idle_busy", {31'd0, busy_o}, 32'd0);

    // Abort by reset at bit 10
    clear_frame();
    enable_i = 1'b1;
    for (int i = 0; i < 200 && n_rise < 10; i++) tick();
    check("abort_rises_before", n_rise, 32'd10);
    check("abort_sclk_high_before", {31'd0, sclk_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", {31'd0, cs_n_o}, 32'd1);
    check("abort_sclk", {31'd0, sclk_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_mosi", {31'd0, mosi_o}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_done", n_done, 32'd0);
    check("abort_no_repop", n_pop, 32'd1);
    check("abort_idle_busy", {31'd0, busy_o}, 32'd0);

    // Whole-run invariants
    check("never_pop_when_empty", n_bad_pop, 32'd0);
    check("sclk_low_while_cs_high", n_sclk_bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
